// File: rtl/clmul_digit_serial.sv
// Digit-serial carry-less (GF(2) polynomial) multiplier.
// Consumes D bits of the multiplier per cycle. The unreduced 2W-1 bit product
// is held on y with a valid/ready handshake until the consumer takes it.
module clmul_digit_serial #(
    parameter int W = 18,
    parameter int D = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-2:0]   y
);

    localparam int N  = (W + D - 1) / D;
    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
    localparam int YW = 2 * W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [YW-1:0]   a_sh_q, a_sh_d;   // multiplicand, pre-shifted by k*D
    logic [W-1:0]    b_sh_q, b_sh_d;   // multiplier, current digit in the low D bits
    logic [YW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [YW-1:0]   pp;

    // Partial product of the shifted multiplicand with the current digit.
    // Once b has been shifted right, bits beyond W read as zero, which
    // pads a ragged final digit.
    always_comb begin
        pp = '0;
        for (int unsigned j = 0; j < D; j++) begin
            if (b_sh_q[j]) begin
                pp = pp ^ (a_sh_q << j);
            end
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = YW'(a);
                    b_sh_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d  = acc_q ^ pp;
                a_sh_d = a_sh_q << D;
                b_sh_d = b_sh_q >> D;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The product is exposed only while it is valid; otherwise y reads zero.
    always_comb begin
        y = (state_q == DONE) ? acc_q : '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, accumulator and digit counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_clmul_digit_serial.sv
// Directed bench for clmul_digit_serial: main instance W=18/D=4 plus
// W=18 instances at D=1, D=5 and D=18 driven from a shared input set.
module tb_clmul_digit_serial;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [17:0] a, b;
    logic [34:0] y;

    logic        xin_valid, xout_ready;
    logic [17:0] xa, xb;
    logic        rdy1, ov1, rdy5, ov5, rdy18, ov18;
    logic [34:0] y1, y5, y18;

    int          total;
    int          passed;
    int          fails;

    logic [34:0] expq[$];
    int          accepts, results, cyc, last_acc;
    logic        rdy, ov_seen;

    clmul_digit_serial #(.W(18), .D(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y));

    clmul_digit_serial #(.W(18), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(xin_valid), .in_ready(rdy1),
        .a(xa), .b(xb), .out_valid(ov1), .out_ready(xout_ready), .y(y1));

    clmul_digit_serial #(.W(18), .D(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .in_valid(xin_valid), .in_ready(rdy5),
        .a(xa), .b(xb), .out_valid(ov5), .out_ready(xout_ready), .y(y5));

    clmul_digit_serial #(.W(18), .D(18)) u_d18 (
        .clk(clk), .rst_n(rst_n), .in_valid(xin_valid), .in_ready(rdy18),
        .a(xa), .b(xb), .out_valid(ov18), .out_ready(xout_ready), .y(y18));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] ref_clmul(input logic [17:0] x, input logic [17:0] z);
        logic [34:0] r;
        r = '0;
        for (int unsigned i = 0; i < 18; i++) begin
            for (int unsigned j = 0; j < 18; j++) begin
                if (x[i] && z[j]) r[i+j] = ~r[i+j];
            end
        end
        return r;
    endfunction

    // One operation on the D=4 instance, checking latency and result.
    task automatic run_op(input string tag, input logic [17:0] va, input logic [17:0] vb,
                          input logic [34:0] ey, input int elat);
        int lat;
        lat = 0;
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        a = 18'($urandom()); b = 18'($urandom());
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(elat));
        chk({tag, "/y"}, 64'(y), 64'(ey));
        chk({tag, "/done_not_ready"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "/consumed_ov"}, 64'(out_valid), 64'd0);
        chk({tag, "/consumed_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "/consumed_y"}, 64'(y), 64'd0);
    endtask

    // One operation on the D=1/5/18 instances together.
    task automatic run_aux(input string tag, input logic [17:0] va, input logic [17:0] vb,
                           input logic [34:0] ey);
        int c, l1, l5, l18;
        c = 0; l1 = 0; l5 = 0; l18 = 0;
        xa = va; xb = vb; xin_valid = 1'b1; xout_ready = 1'b0;
        step();
        xin_valid = 1'b0;
        xa = 18'($urandom()); xb = 18'($urandom());
        while ((l1 == 0 || l5 == 0 || l18 == 0) && c < 40) begin
            step();
            c++;
            if (ov1 === 1'b1 && l1 == 0) l1 = c;
            if (ov5 === 1'b1 && l5 == 0) l5 = c;
            if (ov18 === 1'b1 && l18 == 0) l18 = c;
        end
        chk({tag, "/d1_latency"}, 64'(l1), 64'd18);
        chk({tag, "/d5_latency"}, 64'(l5), 64'd4);
        chk({tag, "/d18_latency"}, 64'(l18), 64'd1);
        chk({tag, "/d1_y"}, 64'(y1), 64'(ey));
        chk({tag, "/d5_y"}, 64'(y5), 64'(ey));
        chk({tag, "/d18_y"}, 64'(y18), 64'(ey));
        xout_ready = 1'b1;
        step();
        xout_ready = 1'b0;
        chk({tag, "/idle_ready"}, 64'({rdy1, rdy5, rdy18}), 64'b111);
        chk({tag, "/idle_y"}, 64'(y1 | y5 | y18), 64'd0);
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0; a = 18'h3FFFF; b = 18'h3FFFF;
        xin_valid = 1'b1; xout_ready = 1'b0; xa = 18'h3FFFF; xb = 18'h3FFFF;

        // Reset held with in_valid asserted: nothing may be accepted.
        step();
        step();
        chk("reset/in_ready", 64'(in_ready), 64'd1);
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/y", 64'(y), 64'd0);
        chk("reset/aux_ready", 64'({rdy1, rdy5, rdy18}), 64'b111);
        rst_n = 1'b1;
        in_valid = 1'b0; xin_valid = 1'b0;
        step();
        chk("post_reset/in_ready", 64'(in_ready), 64'd1);
        chk("post_reset/out_valid", 64'(out_valid), 64'd0);

        // Directed products, D=4 (N=5).
        run_op("d4_ones_x1", 18'h3FFFF, 18'h00001, 35'h3FFFF, 5);
        run_op("d4_ones_sq", 18'h3FFFF, 18'h3FFFF, 35'h555555555, 5);
        run_op("d4_msb_sq", 18'h20000, 18'h20000, 35'h400000000, 5);
        run_op("d4_3x3", 18'h00003, 18'h00003, 35'h5, 5);
        run_op("d4_zero", 18'h00000, 18'h3FFFF, 35'h0, 5);
        run_op("d4_5x3", 18'h00005, 18'h00003, 35'hF, 5);

        // Backpressure: hold DONE for 10 cycles while in_valid toggles.
        a = 18'h3; b = 18'h3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 10; i++) begin
            chk("bp/out_valid", 64'(out_valid), 64'd1);
            chk("bp/y", 64'(y), 64'h5);
            chk("bp/in_ready", 64'(in_ready), 64'd0);
            in_valid = ~in_valid;
            a = 18'($urandom()); b = 18'($urandom());
            step();
        end
        in_valid = 1'b0;
        chk("bp/final_y", 64'(y), 64'h5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp/release_ready", 64'(in_ready), 64'd1);
        chk("bp/release_ov", 64'(out_valid), 64'd0);

        // Reset while digit 2 is about to be processed.
        a = 18'h3FFFF; b = 18'h3FFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_busy/in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy/out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy/y", 64'(y), 64'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            ov_seen = ov_seen | out_valid;
        end
        chk("rst_busy/no_stale_ov", 64'(ov_seen), 64'd0);
        run_op("rst_then_5x3", 18'h00005, 18'h00003, 35'hF, 5);

        // Back-to-back random traffic with both handshakes held high.
        accepts = 0; results = 0; cyc = 0; last_acc = -1;
        a = 18'($urandom()); b = 18'($urandom());
        in_valid = 1'b1; out_ready = 1'b1;
        while (results < 1000 && cyc < 8000) begin
            rdy = in_ready;
            step();
            cyc++;
            if (rdy && in_valid) begin
                expq.push_back(ref_clmul(a, b));
                if (last_acc >= 0) chk("b2b/interval", 64'(cyc - last_acc), 64'd7);
                last_acc = cyc;
                accepts++;
                a = 18'($urandom()); b = 18'($urandom());
                if (accepts == 1000) in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                if (expq.size() > 0) chk("b2b/y", 64'(y), 64'(expq.pop_front()));
                else chk("b2b/spurious_ov", 64'(out_valid), 64'd0);
                results++;
            end
        end
        chk("b2b/result_count", 64'(results), 64'd1000);
        in_valid = 1'b0; out_ready = 1'b0;

        // Other digit sizes: D=1, D=5 (ragged last digit), D=18.
        run_aux("dx_ones_x1", 18'h3FFFF, 18'h00001, 35'h3FFFF);
        run_aux("dx_ones_sq", 18'h3FFFF, 18'h3FFFF, 35'h555555555);
        run_aux("dx_msb_sq", 18'h20000, 18'h20000, 35'h400000000);
        run_aux("dx_3x3", 18'h00003, 18'h00003, 35'h5);
        run_aux("dx_b_top", 18'h00001, 18'h30000, 35'h30000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clmul_digit_serial.md
CLMUL_DIGIT_SERIAL -- requirements
Module: clmul_digit_serial

Interface
REQ-001 SHALL have parameter W, default 18: operand width in bits; legal range 2..512.
REQ-002 SHALL have parameter D, default 4: digit size, i.e. b bits consumed per cycle; legal range 1..W.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock domain, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a/b valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  W  multiplicand, GF(2) polynomial, bit i = coeff of x^i.
REQ-008 SHALL have port b  input  W  multiplier, same encoding.
REQ-009 SHALL have port out_valid  output  1  y holds a completed product.
REQ-010 SHALL have port out_ready  input  1  consumer accepts y.
REQ-011 SHALL have port y  output  2W-1  carry-less product a*b over GF(2), unreduced.

Function
REQ-012 SHALL compute y[k] = XOR over i+j=k of (a[i] AND b[j]), k = 0..2W-2; no carries.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; only these are reachable.
REQ-014 SHALL drive in_ready=1 in IDLE only; 0 in BUSY and DONE.
REQ-015 SHALL accept operands on an edge where in_valid=1 and in_ready=1: register a and b internally, clear accumulator, zero the digit counter, go to BUSY.
REQ-016 SHALL ignore a, b and in_valid in every cycle in which no acceptance occurs.
REQ-017 SHALL, in BUSY digit k (k=0..N-1, N=ceil(W/D)), XOR (a * b[kD+D-1:kD]) << kD into the accumulator, one digit per cycle.
REQ-018 SHALL treat b bits at index >= W in the last digit as zero when W is not a multiple of D.
REQ-019 SHALL go BUSY->DONE on the edge that processes digit N-1; out_valid rises exactly N cycles after the acceptance edge.
REQ-020 SHALL drive out_valid=1 in DONE only, with y stable and equal to the final accumulator for the whole DONE residency.
REQ-021 SHALL, in DONE, hold indefinitely while out_ready=0; on an edge with out_ready=1 go to IDLE (in_ready=1 the following cycle).
REQ-022 SHALL not accept a new operation in the cycle in which a result is consumed; minimum issue interval is N+2 cycles.
REQ-023 SHALL give y = 0 (not X) whenever out_valid=0; y is only meaningful when out_valid=1.
REQ-024 SHALL give correct results for zero operands, all-ones operands, and D=W (single BUSY cycle) and D=1 (W BUSY cycles).
REQ-025 SHALL size the digit counter to ceil(log2(N+1)) bits, with no wrap-around before DONE.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, enter IDLE, clear accumulator, registered operands and digit counter, regardless of current state.
REQ-027 SHALL hold outputs during and right after reset at in_ready=1, out_valid=0, y=0.
REQ-028 SHALL discard any in-flight operation on reset mid-BUSY or mid-DONE; no stale out_valid pulse afterwards.
REQ-029 SHALL ignore in_valid in a cycle with rst_n=0; no acceptance on that edge.

Verification (W=18, D=4, N=5)
REQ-030 SHALL check a=0x3FFFF, b=0x00001 -> y=0x3FFFF, out_valid high exactly 5 cycles after acceptance.
REQ-031 SHALL check a=b=0x3FFFF -> y=0x555555555; a=b=0x20000 -> y=0x400000000; a=b=0x3 -> y=0x5.
REQ-032 SHALL check backpressure: out_ready=0 for 10 cycles in DONE -> y and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL check reset at BUSY digit 2 -> next cycle in_ready=1, out_valid=0, y=0; next op a=0x5,b=0x3 -> y=0xF.
REQ-034 SHALL check back-to-back traffic (in_valid and out_ready held at 1), 1000 random operand pairs -> every y matches the bitwise XOR-of-ANDs reference model, issue interval exactly 7 cycles.
REQ-035 SHALL rerun REQ-030/031 with D=1, D=5 (ragged last digit) and D=18, latency equal to 18, 4 and 1 cycles respectively.
